cdb_arbiter: RTL and testbench

- Parametrised successor to the fixed pair of single-producer CDBs (add, load).
- Accepts results from NUM_SRC functional units, buffers each in a per-source queue, and round-robin arbitrates them onto NUM_BUS registered broadcast lanes.
- Lanes are consumed by reservation stations and the reorder buffer.
- Sits between the functional units and all CDB listeners; a ROB flush (mispredict resetAll) discards everything in flight.

---
 rtl/cdb_pkg.sv | 19 +
 rtl/cdb_arbiter_if.sv | 35 +++
 rtl/cdb_src_queue.sv | 67 ++++++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared widths, source ids and sizing helpers for the common data bus arbiter.
package cdb_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ROB_W  = 4;

  typedef enum logic [1:0] {
    SRC_ADD   = 2'd0,
    SRC_LOAD  = 2'd1,
    SRC_BNE   = 2'd2,
    SRC_STORE = 2'd3
  } src_id_e;

  // Width of a source id; a lone source still needs one bit to be addressable.
  function automatic int src_id_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side results and broadcast lanes of the common data bus, flattened per source/lane.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_BUS = 2,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ROB_W   = DEFAULT_ROB_W
);

  localparam int SRC_W = src_id_w(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ROB_W-1:0]  src_rob;
  logic [NUM_SRC*DATA_W-1:0] src_data;

  logic [NUM_BUS-1:0]        bus_valid;
  logic [NUM_BUS*ROB_W-1:0]  bus_rob;
  logic [NUM_BUS*DATA_W-1:0] bus_data;
  logic [NUM_BUS*SRC_W-1:0]  bus_src;

  // Functional units and listeners.
  modport master (
    output src_valid, src_rob, src_data,
    input  src_ready, bus_valid, bus_rob, bus_data, bus_src
  );

  // The arbiter.
  modport slave (
    input  src_valid, src_rob, src_data,
    output src_ready, bus_valid, bus_rob, bus_data, bus_src
  );

endinterface

// File: rtl/cdb_src_queue.sv
// Per-source result FIFO: QDEPTH entries of {rob, data}, synchronous flush, head always visible.
module cdb_src_queue #(
  parameter int QDEPTH  = 2,
  parameter int ENTRY_W = 36
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] push_entry_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [ENTRY_W-1:0] head_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic [ENTRY_W-1:0] mem_q [QDEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail_q <= next_ptr(tail_q);
      if (pop_ok)  head_q <= next_ptr(head_q);
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_entry_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers results from NUM_SRC units and round-robins them onto NUM_BUS registered broadcast lanes.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_BUS = 2,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ROB_W   = DEFAULT_ROB_W,
  parameter int QDEPTH  = 2
) (
  input logic          clock,
  input logic          reset_n,
  input logic          flush,
  cdb_arbiter_if.slave cdb
);

  localparam int SRC_W   = src_id_w(NUM_SRC);
  localparam int ENTRY_W = ROB_W + DATA_W;

  logic [NUM_SRC-1:0] full, empty, push, pop, grant;
  logic [ENTRY_W-1:0] head [NUM_SRC];

  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [NUM_BUS-1:0] lane_valid_d;
  logic [SRC_W-1:0]   lane_src_d [NUM_BUS];

  logic [NUM_BUS-1:0]        bus_valid_q;
  logic [NUM_BUS*ROB_W-1:0]  bus_rob_q;
  logic [NUM_BUS*DATA_W-1:0] bus_data_q;
  logic [NUM_BUS*SRC_W-1:0]  bus_src_q;

  // Ready comes from registered occupancy only: a full queue refuses even while being popped.
  assign cdb.src_ready = ~full;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_queue
    assign push[g] = cdb.src_valid[g] & ~full[g] & ~flush;
    assign pop[g]  = grant[g] & ~flush;

    cdb_src_queue #(
      .QDEPTH  (QDEPTH),
      .ENTRY_W (ENTRY_W)
    ) u_queue (
      .clk          (clock),
      .rst_n        (reset_n),
      .flush_i      (flush),
      .push_i       (push[g]),
      .pop_i        (pop[g]),
      .push_entry_i ({cdb.src_rob[g*ROB_W +: ROB_W], cdb.src_data[g*DATA_W +: DATA_W]}),
      .full_o       (full[g]),
      .empty_o      (empty[g]),
      .head_o       (head[g])
    );
  end

  // Scan from rr_q; the first NUM_BUS non-empty queues fill lanes 0, 1, ... in scan order.
  always_comb begin
    int n;
    int idx;
    grant        = '0;
    lane_valid_d = '0;
    rr_d         = rr_q;
    n            = 0;
    idx          = 0;
    for (int k = 0; k < NUM_BUS; k++) lane_src_d[k] = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      idx = (int'(rr_q) + off) % NUM_SRC;
      if (!empty[idx] && n < NUM_BUS) begin
        grant[idx]      = 1'b1;
        lane_valid_d[n] = 1'b1;
        lane_src_d[n]   = SRC_W'(idx);
        rr_d            = SRC_W'((idx + 1) % NUM_SRC);
        n++;
      end
    end
  end

  // Idle lanes keep their last rob/data/src; only bus_valid drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_valid_q <= '0;
      bus_rob_q   <= '0;
      bus_data_q  <= '0;
      bus_src_q   <= '0;
      rr_q        <= '0;
    end else if (flush) begin
      bus_valid_q <= '0;
      rr_q        <= '0;
    end else begin
      bus_valid_q <= lane_valid_d;
      rr_q        <= rr_d;
      for (int k = 0; k < NUM_BUS; k++) begin
        if (lane_valid_d[k]) begin
          bus_rob_q[k*ROB_W +: ROB_W]    <= head[lane_src_d[k]][ENTRY_W-1 -: ROB_W];
          bus_data_q[k*DATA_W +: DATA_W] <= head[lane_src_d[k]][DATA_W-1:0];
          bus_src_q[k*SRC_W +: SRC_W]    <= lane_src_d[k];
        end
      end
    end
  end

  assign cdb.bus_valid = bus_valid_q;
  assign cdb.bus_rob   = bus_rob_q;
  assign cdb.bus_data  = bus_data_q;
  assign cdb.bus_src   = bus_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, backpressure, flush, async reset.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int NUM_BUS = 2;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 4;
  localparam int QDEPTH  = 2;
  localparam int SRC_W   = src_id_w(NUM_SRC);

  logic clock = 1'b0;
  logic reset_n;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  logic [ROB_W+DATA_W-1:0] exp_q [NUM_SRC][$];

  cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .NUM_BUS(NUM_BUS), .DATA_W(DATA_W), .ROB_W(ROB_W)) cdb ();

  cdb_arbiter #(
    .NUM_SRC (NUM_SRC),
    .NUM_BUS (NUM_BUS),
    .DATA_W  (DATA_W),
    .ROB_W   (ROB_W),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .cdb     (cdb)
  );

  always #5 clock = ~clock;

  function automatic logic [ROB_W-1:0] lane_rob(input int k);
    return cdb.bus_rob[k*ROB_W +: ROB_W];
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input int k);
    return cdb.bus_data[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [SRC_W-1:0] lane_src(input int k);
    return cdb.bus_src[k*SRC_W +: SRC_W];
  endfunction

  // Inputs change right after a falling edge; outputs are read at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_src();
    cdb.src_valid = '0;
    cdb.src_rob   = '0;
    cdb.src_data  = '0;
  endtask

  task automatic drive_src(input int s, input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] data);
    cdb.src_valid[s]                 = 1'b1;
    cdb.src_rob[s*ROB_W +: ROB_W]    = rob;
    cdb.src_data[s*DATA_W +: DATA_W] = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    clear_src();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    clear_src();
    step();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL reset_bus_valid got=%b exp=00", cdb.bus_valid); end
    checks++; if (cdb.bus_rob !== '0) begin failures++; $display("FAIL reset_bus_rob got=%h exp=0", cdb.bus_rob); end
    checks++; if (cdb.bus_data !== '0) begin failures++; $display("FAIL reset_bus_data got=%h exp=0", cdb.bus_data); end
    checks++; if (cdb.bus_src !== '0) begin failures++; $display("FAIL reset_bus_src got=%h exp=0", cdb.bus_src); end
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL idle_bus_valid cycle=%0d got=%b exp=00", c, cdb.bus_valid); end
      checks++; if (cdb.src_ready !== 4'b1111) begin failures++; $display("FAIL idle_src_ready cycle=%0d got=%b exp=1111", c, cdb.src_ready); end
    end
  endtask

  task automatic test_single();
    do_reset();
    drive_src(SRC_LOAD, 4'd5, 32'h1234);
    step();
    clear_src();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL single_latency got=%b exp=00", cdb.bus_valid); end
    step();
    checks++; if (cdb.bus_valid !== 2'b01) begin failures++; $display("FAIL single_valid got=%b exp=01", cdb.bus_valid); end
    checks++; if (lane_rob(0) !== 4'd5) begin failures++; $display("FAIL single_rob got=%0d exp=5", lane_rob(0)); end
    checks++; if (lane_data(0) !== 32'h1234) begin failures++; $display("FAIL single_data got=%h exp=00001234", lane_data(0)); end
    checks++; if (lane_src(0) !== 2'd1) begin failures++; $display("FAIL single_src got=%0d exp=1", lane_src(0)); end
    step();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL single_one_cycle got=%b exp=00", cdb.bus_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) drive_src(s, 4'(s + 1), 32'hA0 + 32'(s));
    step();
    clear_src();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL cont_latency got=%b exp=00", cdb.bus_valid); end
    step();
    checks++; if (cdb.bus_valid !== 2'b11) begin failures++; $display("FAIL cont_c1_valid got=%b exp=11", cdb.bus_valid); end
    checks++; if ({lane_src(1), lane_src(0)} !== {2'd1, 2'd0}) begin failures++; $display("FAIL cont_c1_src got=%0d,%0d exp=0,1", lane_src(0), lane_src(1)); end
    checks++; if ({lane_rob(1), lane_rob(0)} !== {4'd2, 4'd1}) begin failures++; $display("FAIL cont_c1_rob got=%0d,%0d exp=1,2", lane_rob(0), lane_rob(1)); end
    checks++; if (lane_data(1) !== 32'hA1) begin failures++; $display("FAIL cont_c1_data1 got=%h exp=000000a1", lane_data(1)); end
    step();
    checks++; if (cdb.bus_valid !== 2'b11) begin failures++; $display("FAIL cont_c2_valid got=%b exp=11", cdb.bus_valid); end
    checks++; if ({lane_src(1), lane_src(0)} !== {2'd3, 2'd2}) begin failures++; $display("FAIL cont_c2_src got=%0d,%0d exp=2,3", lane_src(0), lane_src(1)); end
    checks++; if ({lane_rob(1), lane_rob(0)} !== {4'd4, 4'd3}) begin failures++; $display("FAIL cont_c2_rob got=%0d,%0d exp=3,4", lane_rob(0), lane_rob(1)); end
    checks++; if (lane_data(0) !== 32'hA2) begin failures++; $display("FAIL cont_c2_data0 got=%h exp=000000a2", lane_data(0)); end
    step();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL cont_drained got=%b exp=00", cdb.bus_valid); end
    checks++; if (lane_rob(0) !== 4'd3) begin failures++; $display("FAIL cont_idle_hold got=%0d exp=3", lane_rob(0)); end
    // rr_ptr is back at 0, so source 0 must take lane 0 ahead of source 3.
    drive_src(3, 4'd10, 32'h3333);
    drive_src(0, 4'd9, 32'h0000_0009);
    step();
    clear_src();
    step();
    checks++; if ({lane_src(1), lane_src(0)} !== {2'd3, 2'd0}) begin failures++; $display("FAIL cont_rr_wrap_src got=%0d,%0d exp=0,3", lane_src(0), lane_src(1)); end
    checks++; if ({lane_rob(1), lane_rob(0)} !== {4'd10, 4'd9}) begin failures++; $display("FAIL cont_rr_wrap_rob got=%0d,%0d exp=9,10", lane_rob(0), lane_rob(1)); end
    step();
  endtask

  task automatic test_backpressure();
    int seq [NUM_SRC];
    int pushed;
    int seen;
    bit saw_full;
    logic [ROB_W+DATA_W-1:0] exp;
    logic [ROB_W+DATA_W-1:0] got;
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) begin
      seq[s] = 0;
      exp_q[s].delete();
    end
    pushed   = 0;
    seen     = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 2) begin
        checks++; if (cdb.src_ready !== 4'b0011) begin failures++; $display("FAIL bp_ready_after_two got=%b exp=0011", cdb.src_ready); end
      end
      clear_src();
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((s == 3) ? (c < 10) : (c < 2)) begin
          drive_src(s, 4'(seq[s]), 32'(s * 256 + seq[s]));
          if (cdb.src_ready[s]) begin
            exp_q[s].push_back({4'(seq[s]), 32'(s * 256 + seq[s])});
            seq[s]++;
            pushed++;
          end
        end
      end
      if (!cdb.src_ready[3]) saw_full = 1'b1;
      step();
      for (int k = 0; k < NUM_BUS; k++) begin
        if (cdb.bus_valid[k]) begin
          seen++;
          got = {lane_rob(k), lane_data(k)};
          checks++;
          if (exp_q[lane_src(k)].size() == 0) begin
            failures++; $display("FAIL bp_unexpected lane=%0d src=%0d got=%h exp=none", k, lane_src(k), got);
          end else begin
            exp = exp_q[lane_src(k)].pop_front();
            if (got !== exp) begin failures++; $display("FAIL bp_order lane=%0d src=%0d got=%h exp=%h", k, lane_src(k), got, exp); end
          end
        end
      end
      if (cdb.bus_valid == 2'b11) begin
        checks++; if (lane_src(0) === lane_src(1)) begin failures++; $display("FAIL bp_dup_src got=%0d,%0d exp=distinct", lane_src(0), lane_src(1)); end
      end
    end
    clear_src();
    checks++; if (!saw_full) begin failures++; $display("FAIL bp_src3_full got=never exp=ready_low"); end
    checks++; if (seen !== pushed) begin failures++; $display("FAIL bp_total got=%0d exp=%0d", seen, pushed); end
    for (int s = 0; s < NUM_SRC; s++) begin
      checks++; if (exp_q[s].size() != 0) begin failures++; $display("FAIL bp_lost src=%0d got=%0d_left exp=0", s, exp_q[s].size()); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) drive_src(s, 4'(8 + s), 32'hF0 + 32'(s));
    step();
    for (int s = 0; s < NUM_SRC; s++) drive_src(s, 4'(12 + s), 32'hF4 + 32'(s));
    step();
    clear_src();
    checks++; if (cdb.src_ready !== 4'b0011) begin failures++; $display("FAIL flush_prefill_ready got=%b exp=0011", cdb.src_ready); end
    flush = 1'b1;
    drive_src(0, 4'd7, 32'h77);
    step();
    flush = 1'b0;
    clear_src();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL flush_bus_valid got=%b exp=00", cdb.bus_valid); end
    checks++; if (cdb.src_ready !== 4'b1111) begin failures++; $display("FAIL flush_src_ready got=%b exp=1111", cdb.src_ready); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL flush_residue cycle=%0d got=%b rob=%h exp=00", c, cdb.bus_valid, cdb.bus_rob); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) drive_src(s, 4'(s + 4), 32'hB0 + 32'(s));
    step();
    clear_src();
    step();
    checks++; if (cdb.bus_valid !== 2'b11) begin failures++; $display("FAIL areset_burst_valid got=%b exp=11", cdb.bus_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL areset_bus_valid got=%b exp=00", cdb.bus_valid); end
    checks++; if ({cdb.bus_rob, cdb.bus_data, cdb.bus_src} !== '0) begin failures++; $display("FAIL areset_lanes got=%h/%h/%h exp=0", cdb.bus_rob, cdb.bus_data, cdb.bus_src); end
    checks++; if (cdb.src_ready !== 4'b1111) begin failures++; $display("FAIL areset_src_ready got=%b exp=1111", cdb.src_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL areset_after got=%b exp=00", cdb.bus_valid); end
    drive_src(1, 4'd3, 32'hC1);
    drive_src(3, 4'd6, 32'hC3);
    step();
    clear_src();
    step();
    checks++; if (cdb.bus_valid !== 2'b11) begin failures++; $display("FAIL areset_new_valid got=%b exp=11", cdb.bus_valid); end
    checks++; if ({lane_src(1), lane_src(0)} !== {2'd3, 2'd1}) begin failures++; $display("FAIL areset_new_src got=%0d,%0d exp=1,3", lane_src(0), lane_src(1)); end
    checks++; if ({lane_data(1), lane_data(0)} !== {32'hC3, 32'hC1}) begin failures++; $display("FAIL areset_new_data got=%h,%h exp=c1,c3", lane_data(0), lane_data(1)); end
    step();
    checks++; if (cdb.bus_valid !== 2'b00) begin failures++; $display("FAIL areset_new_done got=%b exp=00", cdb.bus_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
